// File: rtl/mem_port_ctrl.sv
// mem_port_ctrl
// Sequences single read/write accesses from the control unit onto a
// synchronous RAM with a fixed, parameterised latency. Each access latches
// its address, data and direction, drives the RAM for WAIT_CYCLES+1 cycles,
// then raises a one-cycle done pulse. Requests that cannot be served are
// dropped and recorded in a sticky error flag. Every output is a register.

module mem_port_ctrl #(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 16,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rd_req,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] rd_data,
    output logic              busy,
    output logic              done,
    output logic              drop_err,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    // Counter value on the final ACCESS cycle; the counter starts at 0.
    localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES);

    state_t            state;
    state_t            state_nxt;
    logic [3:0]        cnt;
    logic [3:0]        cnt_nxt;

    logic              busy_nxt;
    logic              done_nxt;
    logic              drop_err_nxt;
    logic              ram_en_nxt;
    logic              ram_we_nxt;
    logic [ADDR_W-1:0] ram_addr_nxt;
    logic [DATA_W-1:0] ram_wdata_nxt;
    logic [DATA_W-1:0] rd_data_nxt;

    logic              any_req;
    logic              access_last;

    assign any_req     = rd_req | wr_req;
    assign access_last = (cnt == LAST_CNT);

    // State, counter and all registered outputs; reset aborts any access.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            drop_err  <= 1'b0;
            ram_en    <= 1'b0;
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
            rd_data   <= '0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            busy      <= busy_nxt;
            done      <= done_nxt;
            drop_err  <= drop_err_nxt;
            ram_en    <= ram_en_nxt;
            ram_we    <= ram_we_nxt;
            ram_addr  <= ram_addr_nxt;
            ram_wdata <= ram_wdata_nxt;
            rd_data   <= rd_data_nxt;
        end
    end

    // Next state and wait counter: IDLE -> ACCESS on a request, ACCESS lasts
    // WAIT_CYCLES+1 cycles, DONE lasts exactly one cycle.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        unique case (state)
            IDLE: begin
                if (any_req) begin
                    state_nxt = ACCESS;
                    cnt_nxt   = '0;
                end
            end
            ACCESS: begin
                if (access_last) begin
                    state_nxt = DONE;
                end else begin
                    cnt_nxt = cnt + 4'd1;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Next values of the registered outputs. The ram_we register doubles as
    // the latched access direction; the RAM drive stays latched through DONE.
    always_comb begin
        ram_en_nxt    = ram_en;
        ram_we_nxt    = ram_we;
        ram_addr_nxt  = ram_addr;
        ram_wdata_nxt = ram_wdata;
        rd_data_nxt   = rd_data;
        done_nxt      = 1'b0;
        drop_err_nxt  = drop_err;
        busy_nxt      = (state_nxt != IDLE);
        unique case (state)
            IDLE: begin
                if (any_req) begin
                    ram_en_nxt    = 1'b1;
                    ram_we_nxt    = wr_req;
                    ram_addr_nxt  = addr_in;
                    ram_wdata_nxt = data_in;
                    if (rd_req && wr_req) begin
                        drop_err_nxt = 1'b1;
                    end
                end
            end
            ACCESS: begin
                if (any_req) begin
                    drop_err_nxt = 1'b1;
                end
                if (access_last) begin
                    ram_en_nxt = 1'b0;
                    ram_we_nxt = 1'b0;
                    done_nxt   = 1'b1;
                    if (!ram_we) begin
                        rd_data_nxt = ram_rdata;
                    end
                end
            end
            DONE: begin
                if (any_req) begin
                    drop_err_nxt = 1'b1;
                end
            end
            default: begin
                ram_en_nxt = 1'b0;
                ram_we_nxt = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_port_ctrl.sv
// tb_mem_port_ctrl
// Directed bench for mem_port_ctrl with WAIT_CYCLES=1: write, read,
// back-to-back read, simultaneous requests, request while busy and reset
// in the middle of an access, against a small one-stage RAM model.

module tb_mem_port_ctrl;

    logic        clk;
    logic        rst_n;
    logic        rd_req;
    logic        wr_req;
    logic [7:0]  addr_in;
    logic [15:0] data_in;
    logic [15:0] rd_data;
    logic        busy;
    logic        done;
    logic        drop_err;
    logic        ram_en;
    logic        ram_we;
    logic [7:0]  ram_addr;
    logic [15:0] ram_wdata;
    logic [15:0] ram_rdata;

    bit   [15:0] mem [256];
    bit   [255:0] written;

    int checks;
    int errors;

    mem_port_ctrl #(
        .ADDR_W(8),
        .DATA_W(16),
        .WAIT_CYCLES(1)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .rd_req(rd_req),
        .wr_req(wr_req),
        .addr_in(addr_in),
        .data_in(data_in),
        .rd_data(rd_data),
        .busy(busy),
        .done(done),
        .drop_err(drop_err),
        .ram_en(ram_en),
        .ram_we(ram_we),
        .ram_addr(ram_addr),
        .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata)
    );

    // 10-unit clock period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model: one register stage of read latency; unwritten words read
    // back as {8'h5A, address}, and data outside a read window is 16'hDEAD.
    always @(posedge clk) begin
        if (ram_en && ram_we) begin
            mem[ram_addr]     <= ram_wdata;
            written[ram_addr] <= 1'b1;
        end
        if (ram_en && !ram_we) begin
            ram_rdata <= written[ram_addr] ? mem[ram_addr] : {8'h5A, ram_addr};
        end else begin
            ram_rdata <= 16'hDEAD;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic rd, input logic wr, input logic [7:0] addr, input logic [15:0] data);
        rd_req  = rd;
        wr_req  = wr;
        addr_in = addr;
        data_in = data;
    endtask

    task automatic nextEdge();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b1;
        applyStimulus(1'b0, 1'b0, 8'h00, 16'h0000);

        // Reset state
        #2 rst_n = 1'b0;
        #1;
        checkOutput("rst_busy",      32'(busy),      32'h0);
        checkOutput("rst_done",      32'(done),      32'h0);
        checkOutput("rst_drop_err",  32'(drop_err),  32'h0);
        checkOutput("rst_ram_en",    32'(ram_en),    32'h0);
        checkOutput("rst_ram_we",    32'(ram_we),    32'h0);
        checkOutput("rst_ram_addr",  32'(ram_addr),  32'h0);
        checkOutput("rst_ram_wdata", 32'(ram_wdata), 32'h0);
        checkOutput("rst_rd_data",   32'(rd_data),   32'h0);
        repeat (2) nextEdge();
        rst_n = 1'b1;
        nextEdge();
        checkOutput("idle_busy", 32'(busy), 32'h0);

        // Write 0xBEEF to 0x12; addr/data change during ACCESS is ignored
        applyStimulus(1'b0, 1'b1, 8'h12, 16'hBEEF);
        nextEdge();
        checkOutput("wr_k_busy",   32'(busy),      32'h1);
        checkOutput("wr_k_en",     32'(ram_en),    32'h1);
        checkOutput("wr_k_we",     32'(ram_we),    32'h1);
        checkOutput("wr_k_addr",   32'(ram_addr),  32'h12);
        checkOutput("wr_k_wdata",  32'(ram_wdata), 32'hBEEF);
        applyStimulus(1'b0, 1'b0, 8'h99, 16'h1111);
        nextEdge();
        checkOutput("wr_k1_en",    32'(ram_en),    32'h1);
        checkOutput("wr_k1_we",    32'(ram_we),    32'h1);
        checkOutput("wr_k1_addr",  32'(ram_addr),  32'h12);
        checkOutput("wr_k1_wdata", 32'(ram_wdata), 32'hBEEF);
        checkOutput("wr_k1_done",  32'(done),      32'h0);
        nextEdge();
        checkOutput("wr_k2_done",  32'(done),      32'h1);
        checkOutput("wr_k2_en",    32'(ram_en),    32'h0);
        checkOutput("wr_k2_we",    32'(ram_we),    32'h0);
        checkOutput("wr_k2_busy",  32'(busy),      32'h1);
        checkOutput("wr_k2_rd",    32'(rd_data),   32'h0);
        nextEdge();
        checkOutput("wr_k3_done",  32'(done),      32'h0);
        checkOutput("wr_k3_busy",  32'(busy),      32'h0);
        checkOutput("wr_mem12",    32'(mem[8'h12]), 32'hBEEF);

        // Read 0x12, then a back-to-back read of 0x05
        applyStimulus(1'b1, 1'b0, 8'h12, 16'h0000);
        nextEdge();
        checkOutput("rd_k_en",     32'(ram_en),    32'h1);
        checkOutput("rd_k_we",     32'(ram_we),    32'h0);
        checkOutput("rd_k_busy",   32'(busy),      32'h1);
        applyStimulus(1'b0, 1'b0, 8'h00, 16'h0000);
        nextEdge();
        checkOutput("rd_k1_en",    32'(ram_en),    32'h1);
        checkOutput("rd_k1_we",    32'(ram_we),    32'h0);
        checkOutput("rd_k1_done",  32'(done),      32'h0);
        nextEdge();
        checkOutput("rd_k2_done",  32'(done),      32'h1);
        checkOutput("rd_k2_data",  32'(rd_data),   32'hBEEF);
        nextEdge();
        checkOutput("rd_k3_done",  32'(done),      32'h0);
        checkOutput("rd_k3_busy",  32'(busy),      32'h0);
        applyStimulus(1'b1, 1'b0, 8'h05, 16'h0000);
        nextEdge();
        checkOutput("b2b_k4_busy", 32'(busy),      32'h1);
        checkOutput("b2b_k4_addr", 32'(ram_addr),  32'h05);
        applyStimulus(1'b0, 1'b0, 8'h00, 16'h0000);
        nextEdge();
        checkOutput("b2b_k5_done", 32'(done),      32'h0);
        nextEdge();
        checkOutput("b2b_k6_done", 32'(done),      32'h1);
        checkOutput("b2b_k6_data", 32'(rd_data),   32'h5A05);
        nextEdge();
        checkOutput("b2b_k7_busy", 32'(busy),      32'h0);
        checkOutput("b2b_drop",    32'(drop_err),  32'h0);

        // Simultaneous read and write: the write wins, the read is dropped
        applyStimulus(1'b1, 1'b1, 8'h05, 16'h1234);
        nextEdge();
        checkOutput("sim_we",      32'(ram_we),    32'h1);
        checkOutput("sim_addr",    32'(ram_addr),  32'h05);
        checkOutput("sim_drop",    32'(drop_err),  32'h1);
        applyStimulus(1'b0, 1'b0, 8'h00, 16'h0000);
        nextEdge();
        nextEdge();
        checkOutput("sim_done",    32'(done),      32'h1);
        checkOutput("sim_rd_keep", 32'(rd_data),   32'h5A05);
        nextEdge();
        checkOutput("sim_busy",    32'(busy),      32'h0);
        checkOutput("sim_mem05",   32'(mem[8'h05]), 32'h1234);

        // Reset clears the sticky flag and rd_data
        rst_n = 1'b0;
        #1;
        checkOutput("rst2_drop",   32'(drop_err),  32'h0);
        checkOutput("rst2_rd",     32'(rd_data),   32'h0);
        nextEdge();
        rst_n = 1'b1;
        nextEdge();

        // Write request while a read is busy is dropped
        applyStimulus(1'b1, 1'b0, 8'h12, 16'h0000);
        nextEdge();
        applyStimulus(1'b0, 1'b1, 8'h40, 16'h7777);
        nextEdge();
        checkOutput("bsy_drop",    32'(drop_err),  32'h1);
        checkOutput("bsy_we",      32'(ram_we),    32'h0);
        applyStimulus(1'b0, 1'b0, 8'h00, 16'h0000);
        nextEdge();
        checkOutput("bsy_done",    32'(done),      32'h1);
        checkOutput("bsy_rd",      32'(rd_data),   32'hBEEF);
        nextEdge();
        checkOutput("bsy_busy",    32'(busy),      32'h0);
        nextEdge();
        checkOutput("bsy_no_en",   32'(ram_en),    32'h0);
        checkOutput("bsy_no_wr40", 32'(written[8'h40]), 32'h0);
        checkOutput("bsy_drop_kp", 32'(drop_err),  32'h1);

        // Reset in the middle of a write, then a normal read of 0x20
        applyStimulus(1'b0, 1'b1, 8'h30, 16'hCAFE);
        nextEdge();
        applyStimulus(1'b0, 1'b0, 8'h00, 16'h0000);
        nextEdge();
        checkOutput("mid_we_pre",  32'(ram_we),    32'h1);
        rst_n = 1'b0;
        #1;
        checkOutput("mid_we",      32'(ram_we),    32'h0);
        checkOutput("mid_en",      32'(ram_en),    32'h0);
        checkOutput("mid_busy",    32'(busy),      32'h0);
        checkOutput("mid_done",    32'(done),      32'h0);
        nextEdge();
        nextEdge();
        checkOutput("mid_no_done", 32'(done),      32'h0);
        rst_n = 1'b1;
        applyStimulus(1'b1, 1'b0, 8'h20, 16'h0000);
        nextEdge();
        checkOutput("post_busy",   32'(busy),      32'h1);
        checkOutput("post_en",     32'(ram_en),    32'h1);
        applyStimulus(1'b0, 1'b0, 8'h00, 16'h0000);
        nextEdge();
        checkOutput("post_k1_done", 32'(done),     32'h0);
        nextEdge();
        checkOutput("post_done",   32'(done),      32'h1);
        checkOutput("post_rd",     32'(rd_data),   32'h5A20);
        nextEdge();
        checkOutput("post_idle",   32'(busy),      32'h0);
        checkOutput("post_drop",   32'(drop_err),  32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_port_ctrl.md
MEM_PORT_CTRL -- requirements
Module: mem_port_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, width of the memory address.
REQ-002 SHALL have parameter DATA_W, default 16, width of the data word, matching the buffer-register data path.
REQ-003 SHALL have parameter WAIT_CYCLES, default 1, legal range 0..15, the number of extra RAM latency cycles.
REQ-004 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-006 SHALL have port rd_req  input  1  read request pulse from the control unit.
REQ-007 SHALL have port wr_req  input  1  write request pulse from the control unit.
REQ-008 SHALL have port addr_in  input  ADDR_W  access address, driven from the address register.
REQ-009 SHALL have port data_in  input  DATA_W  write data, driven from the buffer-register output.
REQ-010 SHALL have port rd_data  output  DATA_W  read result, fed back to the buffer-register RAM input.
REQ-011 SHALL have port busy  output  1  high while an access is in progress.
REQ-012 SHALL have port done  output  1  one-cycle completion pulse.
REQ-013 SHALL have port drop_err  output  1  sticky flag: a request was lost.
REQ-014 SHALL have port ram_en  output  1  RAM enable.
REQ-015 SHALL have port ram_we  output  1  RAM write enable.
REQ-016 SHALL have port ram_addr  output  ADDR_W  RAM address.
REQ-017 SHALL have port ram_wdata  output  DATA_W  RAM write data.
REQ-018 SHALL have port ram_rdata  input  DATA_W  RAM read data, valid WAIT_CYCLES+1 cycles after ram_en rises.

Function
REQ-019 SHALL implement the FSM states IDLE, ACCESS and DONE; all outputs SHALL be registered.
REQ-020 SHALL sample rd_req/wr_req only in IDLE; on a request at edge k it SHALL latch addr_in, data_in and the direction, load the wait counter to 0, and enter ACCESS.
REQ-021 SHALL give wr_req priority if rd_req and wr_req are both high in IDLE; the read SHALL be discarded and drop_err set.
REQ-022 SHALL hold ram_en=1, ram_addr=latched address and ram_wdata=latched data for exactly WAIT_CYCLES+1 cycles in ACCESS; ram_we SHALL equal 1 in that window only for writes.
REQ-023 SHALL increment the counter each ACCESS cycle; at edge k+WAIT_CYCLES+1 it SHALL go to DONE and, for reads, capture ram_rdata into rd_data.
REQ-024 SHALL deassert ram_en/ram_we on entering DONE; done=1 for exactly one cycle in DONE; the next edge SHALL return to IDLE.
REQ-025 SHALL hold busy=1 in ACCESS and DONE and 0 in IDLE; latency from request edge to done is WAIT_CYCLES+2 cycles.
REQ-026 SHALL leave rd_data unchanged by writes; rd_data SHALL hold its value until the next read completes.
REQ-027 SHALL ignore any request seen while busy=1 and set drop_err, which stays 1 until reset.
REQ-028 SHALL ignore changes to addr_in and data_in during ACCESS; the latched values are used.
REQ-029 SHALL accept a request in the first IDLE cycle after DONE (back-to-back period WAIT_CYCLES+3).

Reset
REQ-030 SHALL, while rst_n=0, immediately force state=IDLE, counter=0, busy=0, done=0, drop_err=0, ram_en=0, ram_we=0, ram_addr=0, ram_wdata=0 and rd_data=0.
REQ-031 SHALL abort any access in flight on reset without producing done; the first rising edge with rst_n=1 is a normal IDLE cycle.

Verification (WAIT_CYCLES=1, ADDR_W=8, DATA_W=16)
REQ-032 SHALL cover a write: wr_req, addr 0x12, data 0xBEEF at edge k -> ram_en=ram_we=1, ram_addr=0x12, ram_wdata=0xBEEF for cycles k+1..k+2; done=1 after edge k+2; busy=0 after edge k+3.
REQ-033 SHALL cover a read: RAM[0x12]=0xBEEF, rd_req at edge k -> ram_we=0 throughout; rd_data=0xBEEF and done=1 after edge k+2.
REQ-034 SHALL cover simultaneous requests: rd_req=wr_req=1 at addr 0x05 -> a write occurs and drop_err=1; rd_data is unchanged.
REQ-035 SHALL cover a request while busy: wr_req in cycle k+1 of a read -> it is ignored (no second ram_en window) and drop_err=1 after reset-free run.
REQ-036 SHALL cover reset mid-access: rst_n low during ACCESS of a write -> ram_we=0 immediately and no done; after release a read of 0x20 completes normally in 3 cycles.
REQ-037 SHALL cover back-to-back: a read issued the cycle after done -> accepted, with two done pulses 4 cycles apart.
